// File: rtl/picorv32_mem_initiator.sv
// picorv32_mem_initiator
//   Bus master for the picorv32 native memory interface. Commands are queued
//   in a small FIFO and issued one at a time on the mem_valid/mem_ready
//   handshake; read data and timeout status come back on the rsp_* port.
//
// Ports:
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command push handshake (cmd_ready = FIFO not full)
//   cmd_write/instr/addr/wdata/wstrb   command fields
//   mem_valid/instr/addr/wdata/wstrb   request to the memory responder
//   mem_ready/mem_rdata    responder completion and read data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata/rsp_timeout  read data (0 on timeout) and timeout flag
//   busy                   FSM active or commands still queued
//
// Optional feature: define WRITE_ACK_EN so that a completed write also
// returns a response (rdata 0, timeout 0); without it only reads and
// timeouts respond.
//
//   state  | meaning
//   S_IDLE | no request active; pops the FIFO head and launches it
//   S_REQ  | mem_valid high, waiting for mem_ready or the timeout
//   S_RSP  | response held on rsp_* until rsp_ready
module picorv32_mem_initiator #(
  parameter int SIZE_OF_THE_BUS = 32,
  parameter int CMD_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic                       cmd_instr,
  input  logic [SIZE_OF_THE_BUS-1:0] cmd_addr,
  input  logic [SIZE_OF_THE_BUS-1:0] cmd_wdata,
  input  logic [3:0]                 cmd_wstrb,
  output logic                       mem_valid,
  output logic                       mem_instr,
  output logic [SIZE_OF_THE_BUS-1:0] mem_addr,
  output logic [SIZE_OF_THE_BUS-1:0] mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic                       mem_ready,
  input  logic [SIZE_OF_THE_BUS-1:0] mem_rdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SIZE_OF_THE_BUS-1:0] rsp_rdata,
  output logic                       rsp_timeout,
  output logic                       busy
);

  localparam int W  = SIZE_OF_THE_BUS;
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = 2 * W + 6;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(CMD_DEPTH);
  localparam logic [W-1:0]  WORD_MASK  = ~(W'(3));

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  state_t        state;
  logic [CW-1:0] fifo_mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop;
  logic [CW-1:0] cmd_word, head;
  logic          head_write, head_instr;
  logic [3:0]    head_wstrb;
  logic [W-1:0]  head_addr, head_wdata;
  logic [TW-1:0] timer;
  logic          req_write;

  assign cmd_word   = {cmd_write, cmd_instr, cmd_wstrb, cmd_addr, cmd_wdata};
  assign head       = fifo_mem[rd_ptr];
  assign head_write = head[CW-1];
  assign head_instr = head[CW-2];
  assign head_wstrb = head[CW-3 -: 4];
  assign head_addr  = head[2*W-1 -: W];
  assign head_wdata = head[W-1:0];

  assign push = cmd_valid && cmd_ready;
  // Popping only from IDLE gives the mandatory one-cycle gap between requests.
  assign pop  = (state == S_IDLE) && (count != '0);
  assign busy = (state != S_IDLE) || (count != '0);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + (AW + 1)'(1);
    else if (pop && !push)
      count_next = count - (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= cmd_word;
  end

  // cmd_ready is registered from the next occupancy, so a pop from a full
  // FIFO only reopens the port one cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      cmd_ready <= (count_next != FULL_COUNT);
    end
  end

  // The timer counts down from TIMEOUT_CYCLES-1; reaching zero with
  // mem_ready still low is the timeout cycle. It stops at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= 4'h0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      timer       <= '0;
      req_write   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            mem_valid <= 1'b1;
            mem_addr  <= head_addr & WORD_MASK;
            mem_instr <= head_write ? 1'b0 : head_instr;
            mem_wdata <= head_write ? head_wdata : '0;
            if (!head_write)
              mem_wstrb <= 4'h0;
            else if (head_wstrb == 4'h0)
              mem_wstrb <= 4'hF;
            else
              mem_wstrb <= head_wstrb;
            req_write <= head_write;
            timer     <= TIMER_LOAD;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (!req_write) begin
              rsp_valid   <= 1'b1;
              rsp_rdata   <= mem_rdata;
              rsp_timeout <= 1'b0;
              state       <= S_RSP;
            end else begin
`ifdef WRITE_ACK_EN
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_timeout <= 1'b0;
              state       <= S_RSP;
`else
              state       <= S_IDLE;
`endif
            end
          end else if (timer == '0) begin
            mem_valid   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            state       <= S_RSP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_initiator.sv
// Testbench for picorv32_mem_initiator: directed scenarios plus randomized
// commands, checked against a queue-based model of the command/response rules.
module tb_picorv32_mem_initiator;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
`ifdef WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_instr;
  logic [W-1:0]  cmd_addr, cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          mem_valid, mem_instr, mem_ready;
  logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [W-1:0]  rsp_rdata;

  picorv32_mem_initiator #(
    .SIZE_OF_THE_BUS(W), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        write;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  cmd_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic wr, input logic ins, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
    cmd_t c;
    c.write = wr; c.instr = ins; c.addr = a; c.wdata = d; c.wstrb = s;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    logic [3:0] s;
    s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, s);
  endfunction

  task automatic push(input cmd_t c);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("push_ready", cmd_ready, 1);
    cmd_write = c.write; cmd_instr = c.instr; cmd_addr = c.addr;
    cmd_wdata = c.wdata; cmd_wstrb = c.wstrb; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    q.push_back(c);
  endtask

  // Responder: mem_ready is raised on the k-th cycle of mem_valid (0-based);
  // a request whose k is at or beyond TMO can only time out.
  task automatic serve(input int k, input int stall, input logic [31:0] rd, output int waited);
    cmd_t        c;
    int          hi;
    bit          timed, exp_rsp;
    logic [31:0] ea, ed, er;
    logic [3:0]  es;
    logic        ei;
    c = q.pop_front();
    waited = 0;
    while (mem_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check("req_start", mem_valid, 1);
    ea = c.addr & 32'hFFFF_FFFC;
    es = c.write ? ((c.wstrb == 4'h0) ? 4'hF : c.wstrb) : 4'h0;
    ed = c.write ? c.wdata : 32'h0;
    ei = c.write ? 1'b0 : c.instr;
    timed = (k >= TMO);
    hi = 0;
    while (mem_valid === 1'b1 && hi < 3 * TMO) begin
      check("mem_addr", mem_addr, ea);
      check("mem_wstrb", mem_wstrb, es);
      check("mem_wdata", mem_wdata, ed);
      check("mem_instr", mem_instr, ei);
      check("rsp_quiet_in_req", rsp_valid, 0);
      mem_ready = (hi == k);
      mem_rdata = (hi == k) ? rd : $urandom;
      step();
      hi++;
    end
    mem_ready = 1'b0;
    check("valid_cycles", hi, timed ? TMO : k + 1);
    check("mem_valid_drop", mem_valid, 0);
    exp_rsp = !c.write || timed || ACK;
    er = (!c.write && !timed) ? rd : 32'h0;
    if (exp_rsp) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_rdata", rsp_rdata, er);
      check("rsp_timeout", rsp_timeout, timed);
      for (int s = 0; s < stall; s++) begin
        step();
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_rdata", rsp_rdata, er);
        check("no_issue_in_rsp", mem_valid, 0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rsp_release", rsp_valid, 0);
      check("gap_after_rsp", mem_valid, 0);
    end else begin
      check("no_write_rsp", rsp_valid, 0);
    end
    check("busy", busy, q.size() != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, acc, npush;
    cmd_t c;

    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_instr = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    #12;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_instr", mem_instr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    resetn = 1'b1;
    step();

    // Directed read: instruction fetch, ready on the third cycle.
    push(mk(1'b0, 1'b1, 32'h103, 32'h0, 4'h0));
    check("no_bypass", mem_valid, 0);
    serve(2, 1, 32'hDEAD_BEEF, w);
    check("pop_latency", w, 1);

    // Directed write, immediate ready.
    push(mk(1'b1, 1'b0, 32'h206, 32'h1234_5678, 4'h3));
    serve(0, 2, 32'h0, w);
    // Write with empty strobe mask.
    push(mk(1'b1, 1'b1, 32'h3FF, 32'hA5A5_0F0F, 4'h0));
    serve(1, 0, 32'h0, w);
    // Read that never gets mem_ready.
    push(mk(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0));
    serve(50, 2, 32'h0, w);
    // Write that times out.
    push(mk(1'b1, 1'b0, 32'h0000_5001, 32'hCAFE_0001, 4'h8));
    serve(TMO + 1, 0, 32'h0, w);
    // mem_ready in the timeout cycle completes normally.
    push(mk(1'b0, 1'b0, 32'h0000_6002, 32'h0, 4'h0));
    serve(TMO - 1, 0, 32'h1357_9BDF, w);

    // Response stall with a second read queued behind it.
    push(mk(1'b0, 1'b0, 32'h0000_7000, 32'h0, 4'h0));
    push(mk(1'b0, 1'b1, 32'h0000_7004, 32'h0, 4'h0));
    serve(1, 5, 32'h1111_2222, w);
    serve(0, 0, 32'h3333_4444, w);

    // Backpressure: responder silent, cmd_valid held high.
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      c = mk(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'h0);
      cmd_write = c.write; cmd_instr = c.instr; cmd_addr = c.addr;
      cmd_wdata = c.wdata; cmd_wstrb = c.wstrb; cmd_valid = 1'b1;
      if (cmd_ready === 1'b1) begin
        acc++;
        q.push_back(c);
      end
      step();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", acc, DEPTH + 1);
    check("bp_cmd_ready_low", cmd_ready, 0);
    w = 0;
    while (rsp_valid !== 1'b1 && w < 30) begin
      check("bp_hold_ready_low", cmd_ready, 0);
      step();
      w++;
    end
    c = q.pop_front();
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_timeout", rsp_timeout, 1);
    check("bp_rsp_rdata", rsp_rdata, 0);
    check("bp_mem_addr", mem_addr, c.addr & 32'hFFFF_FFFC);
    check("bp_ready_in_rsp", cmd_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_ready_still_low", cmd_ready, 0);
    step();
    check("bp_ready_rises", cmd_ready, 1);
    check("bp_next_issue", mem_valid, 1);
    for (int i = 0; i < DEPTH; i++)
      serve($urandom_range(0, 5), $urandom_range(0, 2), $urandom, w);

    // Reset in the middle of a request with commands queued.
    push(rand_cmd());
    push(rand_cmd());
    push(rand_cmd());
    w = 0;
    while (mem_valid !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    step();
    step();
    #2;
    resetn = 1'b0;
    #1;
    check("arst_mem_valid", mem_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_rsp_valid", rsp_valid, 0);
    q.delete();
    step();
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_idle", mem_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    push(mk(1'b0, 1'b0, 32'h0000_8888, 32'h0, 4'h0));
    serve(3, 1, 32'h5555_AAAA, w);

    // Randomized commands: one or two in flight, random latency and stall.
    for (int it = 0; it < 30; it++) begin
      npush = $urandom_range(1, 2);
      for (int j = 0; j < npush; j++)
        push(rand_cmd());
      for (int j = 0; j < npush; j++)
        serve($urandom_range(0, 10), $urandom_range(0, 3), $urandom, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
